// File: rtl/spi_reg_ctrl.sv
// Command sequencer between spi_slave and the register bank: decodes R/W + address,
// runs single/burst accesses with auto-increment and stages read data for the next SPI slot.
module spi_reg_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_transaction_begin,
  input  logic              spi_rx_byte_available,
  input  logic [7:0]        spi_rx_byte,
  output logic [7:0]        spi_tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_rd_valid,
  output logic              rd_timeout_err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_REQ, RD_WAIT, RD_HOLD, WR_DATA
  } state_t;

  state_t            r_state;
  logic [1:0]        r_avail_hist;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_tx;
  logic [7:0]        r_wdata;
  logic              r_wr;
  logic              r_rd;
  logic              r_err;
  logic              w_rx_edge;

  // History holds {older, newer}; a new byte shows up as 0 -> 1.
  assign w_rx_edge = (r_avail_hist == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_avail_hist <= 2'b00;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_tx         <= 8'h00;
      r_wdata      <= 8'h00;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_avail_hist <= {r_avail_hist[0], spi_rx_byte_available};
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      // A new SS assertion restarts everything and swallows any coincident byte.
      if (spi_transaction_begin) begin
        r_state <= CMD;
        r_tx    <= 8'h00;
      end else begin
        case (r_state)
          IDLE: ;
          CMD: begin
            if (w_rx_edge) begin
              r_addr <= spi_rx_byte[ADDR_W-1:0];
              if (spi_rx_byte[7]) begin
                r_state <= WR_DATA;
              end else begin
                r_state <= RD_REQ;
                r_rd    <= 1'b1;
              end
            end
          end
          RD_REQ: begin
            r_cnt   <= CNT_W'(RD_TIMEOUT);
            r_state <= RD_WAIT;
          end
          RD_WAIT: begin
            if (reg_rd_valid) begin
              r_tx    <= reg_rdata;
              r_state <= RD_HOLD;
            end else if (r_cnt <= CNT_W'(1)) begin
              r_tx    <= 8'hFF;
              r_err   <= 1'b1;
              r_state <= RD_HOLD;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          RD_HOLD: begin
            // Master has clocked out the staged byte; prefetch the next address.
            if (w_rx_edge) begin
              r_addr  <= r_addr + ADDR_W'(1);
              r_rd    <= 1'b1;
              r_state <= RD_REQ;
            end
          end
          WR_DATA: begin
            if (r_wr) begin
              r_addr <= r_addr + ADDR_W'(1);
            end else if (w_rx_edge) begin
              r_wdata <= spi_rx_byte;
              r_wr    <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign spi_tx_byte    = r_tx;
  assign reg_addr       = r_addr;
  assign reg_wdata      = r_wdata;
  assign reg_wr         = r_wr;
  assign reg_rd         = r_rd;
  assign rd_timeout_err = r_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: register-bus responder, strobe monitor and
// hand-computed expectations for read, burst write, wrap/timeout, abort, collision and reset.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_transaction_begin = 1'b0;
  logic       spi_rx_byte_available = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic [7:0] spi_tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_rd_valid = 1'b0;
  logic       rd_timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  spi_reg_ctrl #(.ADDR_W(7), .RD_TIMEOUT(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .spi_transaction_begin (spi_transaction_begin),
    .spi_rx_byte_available (spi_rx_byte_available),
    .spi_rx_byte           (spi_rx_byte),
    .spi_tx_byte           (spi_tx_byte),
    .reg_addr              (reg_addr),
    .reg_wdata             (reg_wdata),
    .reg_wr                (reg_wr),
    .reg_rd                (reg_rd),
    .reg_rdata             (reg_rdata),
    .reg_rd_valid          (reg_rd_valid),
    .rd_timeout_err        (rd_timeout_err)
  );

  always #5 clk = ~clk;

  // Register-bus responder: answers resp_delay cycles after the reg_rd cycle.
  int         resp_delay  = 1;
  logic       no_ans_en   = 1'b0;
  logic [6:0] no_ans_addr = 7'h00;
  int         rcnt = 0;
  logic [6:0] raddr = 7'h00;

  function automatic logic [7:0] resp_data(input logic [6:0] a);
    case (a)
      7'h00:   return 8'hC3;
      7'h7F:   return 8'hAA;
      default: return {1'b0, a} ^ 8'h3C;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    reg_rd_valid = 1'b0;
    if (rcnt > 0) begin
      rcnt = rcnt - 1;
      if (rcnt == 0) begin
        reg_rd_valid = 1'b1;
        reg_rdata    = resp_data(raddr);
      end
    end
    if (reg_rd && !(no_ans_en && reg_addr == no_ans_addr)) begin
      rcnt  = resp_delay;
      raddr = reg_addr;
    end
  end

  // Strobe / tx-change monitor, sampled mid-cycle.
  int         cyc = 0;
  int         rd_cyc = 0;
  int         tx_cyc = 0;
  logic [7:0] prev_tx = 8'h00;
  logic [6:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [6:0] rd_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr) begin
        wr_addr_q.push_back(reg_addr);
        wr_data_q.push_back(reg_wdata);
        $display("[%0d] WR addr=%02h data=%02h", cyc, reg_addr, reg_wdata);
      end
      if (reg_rd) begin
        rd_addr_q.push_back(reg_addr);
        rd_cyc = cyc;
        $display("[%0d] RD addr=%02h", cyc, reg_addr);
      end
    end
    if (spi_tx_byte !== prev_tx) begin
      tx_cyc  = cyc;
      prev_tx = spi_tx_byte;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_begin();
    tick();
    spi_transaction_begin = 1'b1;
    tick();
    spi_transaction_begin = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    spi_rx_byte           = b;
    spi_rx_byte_available = 1'b1;
    repeat (8) tick();
    spi_rx_byte_available = 1'b0;
    repeat (30) tick();
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b0;
    chk("rst_tx", spi_tx_byte, 8'h00);
    chk("rst_addr", reg_addr, 7'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_wr", reg_wr, 1'b0);
    chk("rst_rd", reg_rd, 1'b0);
    chk("rst_err", rd_timeout_err, 1'b0);

    // Single read at address 0
    clear_logs();
    pulse_begin();
    send_byte(8'h00);
    @(negedge clk);
    chk("rd1_count", rd_addr_q.size(), 1);
    if (rd_addr_q.size() > 0) chk("rd1_addr", rd_addr_q[0], 7'h00);
    chk("rd1_tx", spi_tx_byte, 8'hC3);
    chk("rd1_latency", tx_cyc - rd_cyc, 2);
    chk("rd1_nowr", wr_addr_q.size(), 0);
    $display("single read done tx=%02h", spi_tx_byte);

    // Burst write 01,02,03 starting at address 1
    clear_logs();
    pulse_begin();
    send_byte(8'h81);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk);
    chk("bw_count", wr_addr_q.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      chk($sformatf("bw_addr%0d", i), wr_addr_q[i], i + 1);
      chk($sformatf("bw_data%0d", i), wr_data_q[i], i + 1);
    end
    chk("bw_tx", spi_tx_byte, 8'h00);
    chk("bw_nord", rd_addr_q.size(), 0);

    // Read at 7F, wrap to 00 which never answers -> timeout
    clear_logs();
    no_ans_en   = 1'b1;
    no_ans_addr = 7'h00;
    pulse_begin();
    send_byte(8'h7F);
    @(negedge clk);
    chk("wrap_tx_aa", spi_tx_byte, 8'hAA);
    chk("wrap_err0", rd_timeout_err, 1'b0);
    send_byte(8'h00);
    @(negedge clk);
    chk("wrap_rd_count", rd_addr_q.size(), 2);
    if (rd_addr_q.size() > 1) chk("wrap_rd_addr", rd_addr_q[1], 7'h00);
    chk("wrap_addr", reg_addr, 7'h00);
    chk("to_tx", spi_tx_byte, 8'hFF);
    chk("to_latency", tx_cyc - rd_cyc, 17);
    chk("to_err", rd_timeout_err, 1'b1);
    no_ans_en = 1'b0;

    // Abort during RD_WAIT; late valid must be ignored
    clear_logs();
    resp_delay = 6;
    pulse_begin();
    tick();
    spi_rx_byte           = 8'h05;
    spi_rx_byte_available = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (reg_rd) seen = 1'b1;
      end
      chk("ab_rd_seen", seen, 1'b1);
    end
    tick();
    tick();
    spi_transaction_begin = 1'b1;
    tick();
    spi_transaction_begin = 1'b0;
    repeat (2) tick();
    spi_rx_byte_available = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("ab_tx", spi_tx_byte, 8'h00);
    chk("ab_rd_count", rd_addr_q.size(), 1);
    chk("ab_nowr", wr_addr_q.size(), 0);
    resp_delay = 1;
    send_byte(8'h86);
    send_byte(8'h77);
    @(negedge clk);
    chk("ab_cmd_wr_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      chk("ab_cmd_wr_addr", wr_addr_q[0], 7'h06);
      chk("ab_cmd_wr_data", wr_data_q[0], 8'h77);
    end

    // Collision: begin and rx_edge in the same cycle while in WR_DATA
    clear_logs();
    tick();
    spi_rx_byte           = 8'h55;
    spi_rx_byte_available = 1'b1;
    tick();
    spi_transaction_begin = 1'b1;
    tick();
    spi_transaction_begin = 1'b0;
    repeat (6) tick();
    spi_rx_byte_available = 1'b0;
    repeat (20) tick();
    send_byte(8'h02);
    @(negedge clk);
    chk("col_nowr", wr_addr_q.size(), 0);
    chk("col_rd_count", rd_addr_q.size(), 1);
    if (rd_addr_q.size() > 0) chk("col_rd_addr", rd_addr_q[0], 7'h02);
    chk("col_tx", spi_tx_byte, 8'h3E);

    // Reset between write data bytes
    clear_logs();
    pulse_begin();
    send_byte(8'h90);
    send_byte(8'hA1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_tx", spi_tx_byte, 8'h00);
    chk("mr_addr", reg_addr, 7'h00);
    chk("mr_wdata", reg_wdata, 8'h00);
    chk("mr_wr", reg_wr, 1'b0);
    chk("mr_rd", reg_rd, 1'b0);
    chk("mr_err", rd_timeout_err, 1'b0);
    send_byte(8'hB2);
    send_byte(8'hC3);
    @(negedge clk);
    chk("mr_ignored_wr", wr_addr_q.size(), 1);
    chk("mr_ignored_rd", rd_addr_q.size(), 0);
    if (wr_addr_q.size() > 0) chk("mr_pre_wr_addr", wr_addr_q[0], 7'h10);
    pulse_begin();
    send_byte(8'h85);
    send_byte(8'h44);
    @(negedge clk);
    chk("mr_after_count", wr_addr_q.size(), 2);
    if (wr_addr_q.size() > 1) begin
      chk("mr_after_addr", wr_addr_q[1], 7'h05);
      chk("mr_after_data", wr_data_q[1], 8'h44);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
